// File: rtl/keypad_scan_scheduler_pkg.sv
// Shared types, constants and helpers for the keypad scan scheduler.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } scan_state_e;

  localparam logic [3:0] ROW0     = 4'b1110;
  localparam logic [3:0] ROW1     = 4'b1101;
  localparam logic [3:0] ROW2     = 4'b1011;
  localparam logic [3:0] ROW3     = 4'b0111;
  localparam logic [3:0] COL_IDLE = 4'hF;

  // True when exactly one column line is pulled low (a real single press).
  function automatic logic one_low(input logic [3:0] col);
    return (col == 4'b1110) || (col == 4'b1101) ||
           (col == 4'b1011) || (col == 4'b0111);
  endfunction

  // Maps the strobed row and the single low column to the printed key code.
  function automatic logic [3:0] key_lookup(input logic [3:0] row, input logic [3:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      {ROW0, 4'b1110}: code = 4'h7;
      {ROW0, 4'b1101}: code = 4'h4;
      {ROW0, 4'b1011}: code = 4'h1;
      {ROW0, 4'b0111}: code = 4'h0;
      {ROW1, 4'b1110}: code = 4'h8;
      {ROW1, 4'b1101}: code = 4'h5;
      {ROW1, 4'b1011}: code = 4'h2;
      {ROW1, 4'b0111}: code = 4'hA;
      {ROW2, 4'b1110}: code = 4'h9;
      {ROW2, 4'b1101}: code = 4'h6;
      {ROW2, 4'b1011}: code = 4'h3;
      {ROW2, 4'b0111}: code = 4'hB;
      {ROW3, 4'b1110}: code = 4'hC;
      {ROW3, 4'b1101}: code = 4'hD;
      {ROW3, 4'b1011}: code = 4'hE;
      {ROW3, 4'b0111}: code = 4'hF;
      default:         code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_scheduler_if.sv
// Valid/ready stream carrying confirmed key codes to consumers.
interface keypad_scan_scheduler_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_scan_scheduler_fifo.sv
// Small key event queue; a push into a full queue succeeds only when a pop frees a slot that same cycle.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             pushOk;
  logic             popOk;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign pushOk  = push_i && (!full_o || pop_i);
  assign popOk   = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clock) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (popOk) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, pushOk} - {{AW{1'b0}}, popOk};
    end
  end

endmodule

// File: rtl/keypad_scan_scheduler.sv
// Keypad scan scheduler: row strobing, settle-timed sampling, press/release debounce and key queueing.
module keypad_scan_scheduler
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES    = 250000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [3:0]                     keypadCol,
  output logic [3:0]                     keypadRow,
  keypad_scan_scheduler_if.master        keyStream,
  output logic                           key_held,
  output logic                           overflow
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_SAMPLES);

  scan_state_e   state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    colLatch_q, colLatch_d;
  logic [3:0]    code_q, code_d;
  logic [CW-1:0] matchCnt_q, matchCnt_d;
  logic [CW-1:0] relCnt_q, relCnt_d;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic          held_q, held_d;
  logic          overflow_q, overflow_d;

  logic          sample;
  logic          push;
  logic          pop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [3:0]    fifoHead;

  assign sample              = (tickCnt_q == TICK_LAST);
  assign pop                 = keyStream.key_valid && keyStream.key_ready;
  assign keyStream.key_valid = !fifoEmpty;
  assign keyStream.key_code  = fifoHead;
  assign keypadRow           = row_q;
  assign key_held            = held_q;
  assign overflow            = overflow_q;

  // Next-state logic: the row only moves on a sample cycle and stays locked while a key is being confirmed or held.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    colLatch_d = colLatch_q;
    code_d     = code_q;
    matchCnt_d = matchCnt_q;
    relCnt_d   = relCnt_q;
    push       = 1'b0;
    tickCnt_d  = sample ? '0 : tickCnt_q + 1'b1;

    if (sample) begin
      case (state_q)
        SCAN: begin
          if (one_low(keypadCol)) begin
            colLatch_d = keypadCol;
            code_d     = key_lookup(row_q, keypadCol);
            matchCnt_d = CW'(1);
            state_d    = CONFIRM;
          end else begin
            row_d = {row_q[2:0], row_q[3]};
          end
        end
        CONFIRM: begin
          if (keypadCol == colLatch_q) begin
            matchCnt_d = matchCnt_q + 1'b1;
            if (matchCnt_q + 1'b1 == DEB_LAST) begin
              push     = 1'b1;
              relCnt_d = '0;
              state_d  = HELD;
            end
          end else begin
            row_d   = {row_q[2:0], row_q[3]};
            state_d = SCAN;
          end
        end
        HELD: begin
          if (keypadCol == COL_IDLE) begin
            relCnt_d = relCnt_q + 1'b1;
            if (relCnt_q + 1'b1 == DEB_LAST) begin
              row_d   = {row_q[2:0], row_q[3]};
              state_d = SCAN;
            end
          end else begin
            relCnt_d = '0;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end

    held_d     = (state_d == HELD);
    overflow_d = overflow_q || (push && fifoFull && !pop);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SCAN;
      row_q      <= ROW0;
      colLatch_q <= COL_IDLE;
      code_q     <= 4'h0;
      matchCnt_q <= '0;
      relCnt_q   <= '0;
      tickCnt_q  <= '0;
      held_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      colLatch_q <= colLatch_d;
      code_q     <= code_d;
      matchCnt_q <= matchCnt_d;
      relCnt_q   <= relCnt_d;
      tickCnt_q  <= tickCnt_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) eventQueue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .data_i  (code_d),
    .pop_i   (pop),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (fifoHead)
  );

endmodule

// File: tb/tb_keypad_scan_scheduler.sv
// Directed bench for the keypad scan scheduler with a small keypad model driving the column lines.
module tb_keypad_scan_scheduler;
  import keypad_pkg::*;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] code;
  } key_vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keypadCol;
  logic [3:0] keypadRow;
  logic       key_held;
  logic       overflow;

  logic       keyActive = 1'b0;
  logic [3:0] keyRow    = ROW0;
  logic [3:0] keyCol    = COL_IDLE;
  logic [3:0] rawCol    = COL_IDLE;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  key_vec_t keyMap [16];

  keypad_scan_scheduler_if keyIf ();

  keypad_scan_scheduler #(
    .SETTLE_CYCLES    (SETTLE),
    .DEBOUNCE_SAMPLES (DEB),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .keypadCol (keypadCol),
    .keypadRow (keypadRow),
    .keyStream (keyIf),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  // A pressed key only pulls its column low while its own row is strobed.
  assign keypadCol = (keyActive && keypadRow == keyRow) ? keyCol : rawCol;

  always #5 clock = ~clock;

  // Cycles since reset release; sample edges fall on multiples of SETTLE.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic nextSample();
    tick(SETTLE);
  endtask

  task automatic alignSample();
    for (int i = 0; i < SETTLE; i++) begin
      if (cyc % SETTLE == 0) break;
      tick(1);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pressKey(input logic [3:0] row, input logic [3:0] col, input logic release_key);
    logic seen;
    keyRow    = row;
    keyCol    = col;
    keyActive = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      nextSample();
      if (key_held) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("pressReachesHeld", 4'(seen), 4'd1);
    if (release_key) begin
      keyActive = 1'b0;
      seen      = 1'b0;
      for (int i = 0; i < 6; i++) begin
        nextSample();
        if (!key_held) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput("releaseLeavesHeld", 4'(seen), 4'd1);
    end
  endtask

  task automatic applyStimulus(input key_vec_t v);
    pressKey(v.row, v.col, 1'b1);
    checkOutput("mapValid", 4'(keyIf.key_valid), 4'd1);
    checkOutput("mapCode", keyIf.key_code, v.code);
    keyIf.key_ready = 1'b1;
    tick(1);
    keyIf.key_ready = 1'b0;
    checkOutput("mapPopped", 4'(keyIf.key_valid), 4'd0);
  endtask

  initial begin
    logic [3:0] drainExp [4];

    keyMap[0]  = '{ROW0, 4'b1110, 4'h7};
    keyMap[1]  = '{ROW0, 4'b1101, 4'h4};
    keyMap[2]  = '{ROW0, 4'b1011, 4'h1};
    keyMap[3]  = '{ROW0, 4'b0111, 4'h0};
    keyMap[4]  = '{ROW1, 4'b1110, 4'h8};
    keyMap[5]  = '{ROW1, 4'b1101, 4'h5};
    keyMap[6]  = '{ROW1, 4'b1011, 4'h2};
    keyMap[7]  = '{ROW1, 4'b0111, 4'hA};
    keyMap[8]  = '{ROW2, 4'b1110, 4'h9};
    keyMap[9]  = '{ROW2, 4'b1101, 4'h6};
    keyMap[10] = '{ROW2, 4'b1011, 4'h3};
    keyMap[11] = '{ROW2, 4'b0111, 4'hB};
    keyMap[12] = '{ROW3, 4'b1110, 4'hC};
    keyMap[13] = '{ROW3, 4'b1101, 4'hD};
    keyMap[14] = '{ROW3, 4'b1011, 4'hE};
    keyMap[15] = '{ROW3, 4'b0111, 4'hF};
    drainExp[0] = 4'h7;
    drainExp[1] = 4'h5;
    drainExp[2] = 4'h3;
    drainExp[3] = 4'hF;

    keyIf.key_ready = 1'b0;

    // Reset values and idle row rotation
    tick(3);
    checkOutput("rstRow", keypadRow, ROW0);
    checkOutput("rstValid", 4'(keyIf.key_valid), 4'd0);
    checkOutput("rstCode", keyIf.key_code, 4'h0);
    checkOutput("rstHeld", 4'(key_held), 4'd0);
    checkOutput("rstOverflow", 4'(overflow), 4'd0);
    reset = 1'b0;
    tick(2);
    checkOutput("rowSettling", keypadRow, ROW0);
    tick(2);
    checkOutput("rot1", keypadRow, ROW1);
    nextSample();
    checkOutput("rot2", keypadRow, ROW2);
    nextSample();
    checkOutput("rot3", keypadRow, ROW3);
    nextSample();
    checkOutput("rotWrap", keypadRow, ROW0);
    checkOutput("idleValid", 4'(keyIf.key_valid), 4'd0);

    // Bounce: one matching sample, then idle
    keyRow = ROW0; keyCol = 4'b1110; keyActive = 1'b1;
    nextSample();
    checkOutput("bounceRowHeld", keypadRow, ROW0);
    keyActive = 1'b0;
    nextSample();
    checkOutput("bounceRowAdv", keypadRow, ROW1);
    checkOutput("bounceNoEvent", 4'(keyIf.key_valid), 4'd0);
    checkOutput("bounceHeld", 4'(key_held), 4'd0);

    // Confirmed press of key 2 on row 1101 with consumer ready
    keyRow = ROW1; keyCol = 4'b1011; keyActive = 1'b1;
    keyIf.key_ready = 1'b1;
    nextSample();
    checkOutput("confRow", keypadRow, ROW1);
    nextSample();
    checkOutput("confNotYet", 4'(keyIf.key_valid), 4'd0);
    nextSample();
    checkOutput("confValid", 4'(keyIf.key_valid), 4'd1);
    checkOutput("confCode", keyIf.key_code, 4'h2);
    checkOutput("confHeld", 4'(key_held), 4'd1);
    tick(1);
    checkOutput("confPopped", 4'(keyIf.key_valid), 4'd0);
    checkOutput("confStillHeld", 4'(key_held), 4'd1);
    keyActive = 1'b0;
    keyIf.key_ready = 1'b0;
    tick(SETTLE - 1);
    nextSample();
    checkOutput("relRowLocked", keypadRow, ROW1);
    checkOutput("relHeld2", 4'(key_held), 4'd1);
    nextSample();
    checkOutput("relRowAdv", keypadRow, ROW2);
    checkOutput("relHeldOff", 4'(key_held), 4'd0);

    // Ghost pattern keeps rotating
    rawCol = 4'b1001;
    nextSample();
    checkOutput("ghostRow1", keypadRow, ROW3);
    checkOutput("ghostHeld", 4'(key_held), 4'd0);
    nextSample();
    checkOutput("ghostRow2", keypadRow, ROW0);
    checkOutput("ghostNoEvent", 4'(keyIf.key_valid), 4'd0);
    rawCol = COL_IDLE;

    // Full key map
    for (int i = 0; i < 16; i++) begin
      applyStimulus(keyMap[i]);
    end

    // Queue fill and overflow with consumer stalled
    pressKey(ROW0, 4'b1110, 1'b1);
    checkOutput("q1Head", keyIf.key_code, 4'h7);
    pressKey(ROW1, 4'b1101, 1'b1);
    pressKey(ROW2, 4'b1011, 1'b1);
    pressKey(ROW3, 4'b0111, 1'b1);
    checkOutput("q4NoOverflow", 4'(overflow), 4'd0);
    checkOutput("q4Head", keyIf.key_code, 4'h7);
    pressKey(ROW0, 4'b0111, 1'b1);
    checkOutput("q5Overflow", 4'(overflow), 4'd1);
    checkOutput("q5Head", keyIf.key_code, 4'h7);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drainValid", 4'(keyIf.key_valid), 4'd1);
      checkOutput("drainCode", keyIf.key_code, drainExp[i]);
      keyIf.key_ready = 1'b1;
      tick(1);
      keyIf.key_ready = 1'b0;
    end
    checkOutput("drainEmpty", 4'(keyIf.key_valid), 4'd0);
    checkOutput("drainCodeZero", keyIf.key_code, 4'h0);
    checkOutput("overflowSticky", 4'(overflow), 4'd1);

    // Reset while held with two queued entries
    pressKey(ROW1, 4'b1110, 1'b1);
    alignSample();
    pressKey(ROW0, 4'b1110, 1'b0);
    tick(2);
    checkOutput("preRstValid", 4'(keyIf.key_valid), 4'd1);
    checkOutput("preRstHead", keyIf.key_code, 4'h8);
    checkOutput("preRstHeld", 4'(key_held), 4'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("midRstValid", 4'(keyIf.key_valid), 4'd0);
    checkOutput("midRstHeld", 4'(key_held), 4'd0);
    checkOutput("midRstRow", keypadRow, ROW0);
    checkOutput("midRstOverflow", 4'(overflow), 4'd0);
    reset = 1'b0;
    nextSample();
    checkOutput("reconf1Held", 4'(key_held), 4'd0);
    checkOutput("reconf1Row", keypadRow, ROW0);
    nextSample();
    checkOutput("reconf2Valid", 4'(keyIf.key_valid), 4'd0);
    nextSample();
    checkOutput("reconf3Held", 4'(key_held), 4'd1);
    checkOutput("reconf3Valid", 4'(keyIf.key_valid), 4'd1);
    checkOutput("reconf3Code", keyIf.key_code, 4'h7);
    keyActive = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
